// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Double-dabble pre-shift correction: a digit of 5 or more would reach 10 or more
  // after doubling, so add 3 now and the shift carries it into the next digit.
  function automatic logic [BCD_DIGIT_W-1:0] add3_adj(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of the double-dabble datapath: add-3 adjust, then shift left by one.
// carry_in enters at the LSB and carry_out is the adjusted MSB, which moves into the next digit.
module bcd_dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   carry_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   carry_out
);

  logic [BCD_DIGIT_W-1:0] adj;

  // Adjust first, then shift the carry in at the bottom.
  always_comb begin
    adj       = add3_adj(digit_in);
    digit_out = {adj[BCD_DIGIT_W-2:0], carry_in};
    carry_out = adj[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using double dabble, one input bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: the input is two's complement.
// The converter works on the magnitude, and the result carries a sign flag.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [BIN_W-1:0]              bin_d_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_d_out,
  output logic                          rdy,
  output logic                          busy,
  output logic                          ovf,
  output logic                          neg
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch, scratch_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_s;
  logic [DIGITS:0]    carry;
  logic [BIN_W-1:0]   mag_in;
  logic               accept, last;

  // The bit chain starts at the binary MSB and ripples up through the digits.
  // Whatever leaves the top digit is weight 10^DIGITS, which means overflow.
  assign carry[0] = bin_sr[BIN_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry_in  (carry[g]),
      .digit_out (scratch_nxt[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry_out (carry[g+1])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sign_in, neg_s;
  assign sign_in = bin_d_in[BIN_W-1];
  // Negating as a BIN_W-bit unsigned value maps -2^(BIN_W-1) onto its own magnitude.
  assign mag_in  = sign_in ? (~bin_d_in + 1'b1) : bin_d_in;

  // The captured sign reaches the output together with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_s <= 1'b0;
      neg   <= 1'b0;
    end else if (accept) begin
      neg_s <= sign_in;
    end else if (last) begin
      neg   <= neg_s;
    end
  end
`else
  assign mag_in = bin_d_in;
  assign neg    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs. DONE accepts a new request just as IDLE does.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    rdy       = 1'b0;
    case (state)
      IDLE: begin
        accept = en;
        if (en) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        last = (cnt == CNT_W'(1));
        if (last) state_nxt = DONE;
      end
      DONE: begin
        rdy       = 1'b1;
        accept    = en;
        state_nxt = en ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift once per cycle, and load the result on the last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr    <= '0;
      scratch   <= '0;
      cnt       <= '0;
      ovf_s     <= 1'b0;
      bcd_d_out <= '0;
      ovf       <= 1'b0;
    end else if (accept) begin
      bin_sr  <= mag_in;
      scratch <= '0;
      ovf_s   <= 1'b0;
      cnt     <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
      scratch <= scratch_nxt;
      ovf_s   <= ovf_s | carry[DIGITS];
      cnt     <= cnt - 1'b1;
      if (last) begin
        bcd_d_out <= scratch_nxt;
        ovf       <= ovf_s | carry[DIGITS];
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and exhaustive checks of bin2bcd_seq. DUT a: 12 bits to 4 digits. DUT b: 12 bits to 3 digits.
// Each start pushes a decimal-arithmetic expectation. A monitor pops it when rdy appears.
module tb_bin2bcd_seq;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [11:0] bin_a = '0, bin_b = '0;
  logic [15:0] bcd_a;
  logic [11:0] bcd_b;
  logic        rdy_a, busy_a, ovf_a, neg_a;
  logic        rdy_b, busy_b, ovf_b, neg_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .bin_d_in(bin_a), .bcd_d_out(bcd_a),
    .rdy(rdy_a), .busy(busy_a), .ovf(ovf_a), .neg(neg_a)
  );

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .bin_d_in(bin_b), .bcd_d_out(bcd_b),
    .rdy(rdy_b), .busy(busy_b), .ovf(ovf_b), .neg(neg_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic exp_t model(input logic [11:0] v, input int digits, input int rc);
    exp_t e;
    int   mag;
    int   lim;
    mag   = int'(v);
    e.neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[11]) begin
      mag   = 4096 - int'(v);
      e.neg = 1'b1;
    end
`endif
    lim   = 10 ** digits;
    e.ovf = (mag >= lim);
    mag   = mag % lim;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.cyc = rc;
    return e;
  endfunction

  // Score DUT a whenever it signals a result.
  always @(negedge clk) begin
    if (rdy_a) begin
      exp_t e;
      checks++;
      assert (qa.size() > 0) else begin errors++; $error("FAIL a_unexpected_rdy got rdy=1 exp no rdy"); end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        checks++;
        assert (bcd_a === e.bcd) else begin errors++; $error("FAIL a_bcd got %h exp %h", bcd_a, e.bcd); end
        checks++;
        assert (ovf_a === e.ovf) else begin errors++; $error("FAIL a_ovf got %b exp %b", ovf_a, e.ovf); end
        checks++;
        assert (neg_a === e.neg) else begin errors++; $error("FAIL a_neg got %b exp %b", neg_a, e.neg); end
        checks++;
        assert (cyc === e.cyc) else begin errors++; $error("FAIL a_latency got cycle %0d exp %0d", cyc, e.cyc); end
        checks++;
        assert (busy_a === 1'b0) else begin errors++; $error("FAIL a_busy_at_rdy got %b exp 0", busy_a); end
      end
    end
  end

  // Score DUT b whenever it signals a result.
  always @(negedge clk) begin
    if (rdy_b) begin
      exp_t e;
      checks++;
      assert (qb.size() > 0) else begin errors++; $error("FAIL b_unexpected_rdy got rdy=1 exp no rdy"); end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        checks++;
        assert (bcd_b === e.bcd[11:0]) else begin errors++; $error("FAIL b_bcd got %h exp %h", bcd_b, e.bcd[11:0]); end
        checks++;
        assert (ovf_b === e.ovf) else begin errors++; $error("FAIL b_ovf got %b exp %b", ovf_b, e.ovf); end
        checks++;
        assert (neg_b === e.neg) else begin errors++; $error("FAIL b_neg got %b exp %b", neg_b, e.neg); end
        checks++;
        assert (cyc === e.cyc) else begin errors++; $error("FAIL b_latency got cycle %0d exp %0d", cyc, e.cyc); end
      end
    end
  end

  // Pulse en for one accepting edge and push the expectation. The DUT must be IDLE or DONE.
  task automatic start(input bit sel, input logic [11:0] v);
    @(posedge clk); #1;
    if (sel) begin en_b = 1'b1; bin_b = v; end
    else     begin en_a = 1'b1; bin_a = v; end
    @(posedge clk); #1;
    en_a = 1'b0;
    en_b = 1'b0;
    if (sel) qb.push_back(model(v, 3, cyc + 12));
    else     qa.push_back(model(v, 4, cyc + 12));
  endtask

  // Wait, with a time limit, until the monitor has consumed every expectation.
  task automatic drain(input bit sel);
    int n;
    n = 0;
    while (((sel ? qb.size() : qa.size()) != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert ((sel ? qb.size() : qa.size()) == 0)
      else begin errors++; $error("FAIL drain_%0d_timeout got %0d pending exp 0", sel, sel ? qb.size() : qa.size()); end
    if (sel) qb.delete();
    else     qa.delete();
  endtask

  task automatic conv(input bit sel, input logic [11:0] v);
    start(sel, v);
    drain(sel);
  endtask

  initial begin
    // Reset state is checked before any clock edge.
    #3;
    checks++;
    assert ({bcd_a, rdy_a, busy_a, ovf_a, neg_a} === 20'h0)
      else begin errors++; $error("FAIL reset_state got %h exp 0", {bcd_a, rdy_a, busy_a, ovf_a, neg_a}); end
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed values at the default parameters.
    conv(0, 12'd1024);
    repeat (3) @(negedge clk);
    checks++;
    assert (bcd_a === 16'h1024) else begin errors++; $error("FAIL hold_bcd got %h exp 1024", bcd_a); end
    checks++;
    assert (rdy_a === 1'b0) else begin errors++; $error("FAIL rdy_one_cycle got %b exp 0", rdy_a); end
    conv(0, 12'd512);
    conv(0, 12'd4095);
    conv(0, 12'd0);

    // Overflow boundary with three digits.
    conv(1, 12'd999);
    conv(1, 12'd1000);
    conv(1, 12'd4095);

    // Hold en high. The input changes while busy must be ignored. Results arrive every 13 cycles.
    @(posedge clk); #1;
    en_a  = 1'b1;
    bin_a = 12'd7;
    @(posedge clk); #1;
    qa.push_back(model(12'd7, 4, cyc + 12));
    for (int k = 0; k < 2; k++) begin
      repeat (12) begin
        bin_a = 12'($urandom_range(0, 4095));
        @(posedge clk); #1;
      end
      bin_a = 12'(8 + k);
      @(posedge clk); #1;
      qa.push_back(model(12'(8 + k), 4, cyc + 12));
    end
    en_a = 1'b0;
    drain(0);

    // Reset 5 cycles into a conversion clears outputs at once, and no rdy follows.
    @(posedge clk); #1;
    en_a  = 1'b1;
    bin_a = 12'd1234;
    @(posedge clk); #1;
    en_a = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    assert ({bcd_a, rdy_a, busy_a, ovf_a, neg_a} === 20'h0)
      else begin errors++; $error("FAIL async_reset got %h exp 0", {bcd_a, rdy_a, busy_a, ovf_a, neg_a}); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    conv(0, 12'd1234);

`ifdef BIN2BCD_SIGNED_EN
    conv(0, 12'hE00);
    conv(0, 12'h800);
    conv(0, 12'd2047);
`endif

    // Exhaustive sweep at the default parameters.
    for (int v = 0; v < 4096; v++) conv(0, 12'(v));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
